// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: requester indices, FSM states and
// the winner-selection helper.
package sram_arbiter_pkg;

  localparam logic [1:0] REQ_VGA  = 2'd0;
  localparam logic [1:0] REQ_M1   = 2'd1;
  localparam logic [1:0] REQ_UART = 2'd2;

  typedef enum logic [1:0] {
    S_ARB_IDLE,
    S_ARB_OWN,
    S_ARB_TURN
  } arb_state_e;

  // VGA always wins; M1 and UART alternate based on who was served last.
  function automatic logic [1:0] pick_winner(input logic [2:0] req,
                                             input logic [1:0] last_served);
    if (req[REQ_VGA]) return REQ_VGA;
    if (req[REQ_M1] && req[REQ_UART]) return (last_served == REQ_UART) ? REQ_M1 : REQ_UART;
    if (req[REQ_M1]) return REQ_M1;
    return REQ_UART;
  endfunction

endpackage

// File: rtl/sram_arb_tag_pipe.sv
// Read-return tag shift register: carries {valid, id} of each granted read
// for DEPTH cycles so the return can be steered to its requester.
module sram_arb_tag_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [1:0] in_id,
  output logic       out_valid,
  output logic [1:0] out_id
);

  logic [DEPTH-1:0] valid_q;
  logic [1:0]       id_q [DEPTH];

  always_ff @(posedge clock_50) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) id_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      id_q[0]    <= in_id;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/sram_arbiter.sv
// Three-way SRAM arbiter (VGA, M1, UART): VGA has priority and preempts,
// M1/UART share round-robin with a bounded burst; reads are returned by tag.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned MAX_BURST    = 16
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       req_we_n,
  input  logic [2:0][17:0] req_address,
  input  logic [2:0][15:0] req_write_data,
  output logic [2:0]       gnt,
  output logic [2:0]       rdata_valid,
  output logic [15:0]      read_data,
  output logic [17:0]      SRAM_address,
  output logic [15:0]      SRAM_write_data,
  output logic             SRAM_we_n,
  input  logic [15:0]      SRAM_read_data
);

  localparam int unsigned       BurstW   = $clog2(MAX_BURST + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [BurstW-1:0] burst_q, burst_d, burst_inc;
  logic [1:0]        winner, peer;
  logic              granted, other_req, preempt, burst_out;
  logic              tag_valid;
  logic [1:0]        tag_id;
  logic [15:0]       read_data_q;

  assign winner  = pick_winner(req, last_q);
  assign peer    = (owner_q == REQ_M1) ? REQ_UART : REQ_M1;
  assign granted = |gnt;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q <= S_ARB_IDLE;
      owner_q <= REQ_VGA;
      last_q  <= REQ_UART;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    burst_d   = burst_q;
    burst_inc = (granted && burst_q != BurstMax) ? burst_q + 1'b1 : burst_q;
    other_req = |(req & ~(3'b001 << owner_q));
    preempt   = (owner_q != REQ_VGA) && req[REQ_VGA];
    // The limit is tested on the count including this cycle's access, so a
    // full burst hands over right after its last grant.
    burst_out = (owner_q != REQ_VGA) && (burst_inc == BurstMax) && req[peer];
    case (state_q)
      S_ARB_IDLE, S_ARB_TURN: begin
        if (|req) begin
          state_d = S_ARB_OWN;
          owner_d = winner;
          burst_d = '0;
          if (winner != REQ_VGA) last_d = winner;
        end else begin
          state_d = S_ARB_IDLE;
        end
      end
      S_ARB_OWN: begin
        burst_d = burst_inc;
        if ((!req[owner_q] && other_req) || preempt || burst_out) state_d = S_ARB_TURN;
        else if (!req[owner_q]) state_d = S_ARB_IDLE;
      end
      default: state_d = S_ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state_q == S_ARB_OWN) gnt[owner_q] = req[owner_q];
    rdata_valid = '0;
    if (tag_valid) rdata_valid[tag_id] = 1'b1;
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      read_data_q     <= '0;
    end else begin
      read_data_q <= SRAM_read_data;
      if (granted) begin
        SRAM_address    <= req_address[owner_q];
        SRAM_write_data <= req_write_data[owner_q];
        SRAM_we_n       <= req_we_n[owner_q];
      end else begin
        SRAM_we_n <= 1'b1;
      end
    end
  end

  assign read_data = read_data_q;

  sram_arb_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_tag_pipe (
    .clock_50 (clock_50),
    .reset    (reset),
    .in_valid (granted && req_we_n[owner_q]),
    .in_id    (owner_q),
    .out_valid(tag_valid),
    .out_id   (tag_id)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: stimulus pushes timed expectations into
// queues, a negedge monitor compares grants and read returns against them.
module tb_sram_arbiter;

  logic             clock_50 = 1'b0;
  logic             reset;
  logic [2:0]       req, req_we_n, gnt, rdata_valid;
  logic [2:0][17:0] req_address;
  logic [2:0][15:0] req_write_data;
  logic [15:0]      read_data, SRAM_write_data, SRAM_read_data, rd_pipe;
  logic [17:0]      SRAM_address;
  logic             SRAM_we_n;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [2:0] val; } gnt_exp_t;
  typedef struct { int cyc; logic [2:0] id; logic [15:0] data; } rd_exp_t;
  gnt_exp_t eg[$];
  rd_exp_t  er[$];

  sram_arbiter dut (
    .clock_50       (clock_50),
    .reset          (reset),
    .req            (req),
    .req_we_n       (req_we_n),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .gnt            (gnt),
    .rdata_valid    (rdata_valid),
    .read_data      (read_data),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .SRAM_read_data (SRAM_read_data)
  );

  always #10 clock_50 = ~clock_50;
  always @(posedge clock_50) cyc <= cyc + 1;

  function automatic logic [15:0] sram_f(input logic [17:0] a);
    return a[15:0] ^ {a[17:16], a[17:16], 12'h5C3};
  endfunction

  // SRAM controller model: data for the address on the port appears one cycle later.
  always @(posedge clock_50) rd_pipe <= sram_f(SRAM_address);
  assign SRAM_read_data = rd_pipe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock_50);
    #1;
  endtask

  task automatic push_g(input int c, input logic [2:0] v);
    eg.push_back('{cyc: c, val: v});
  endtask

  task automatic push_r(input int c, input logic [2:0] id, input logic [17:0] a);
    er.push_back('{cyc: c, id: id, data: sram_f(a)});
  endtask

  always @(negedge clock_50) begin
    if (!reset) begin
      while (eg.size() > 0 && eg[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL gnt_stale: expected %0h at cycle %0d never seen", eg[0].val, eg[0].cyc);
        void'(eg.pop_front());
      end
      if (eg.size() > 0 && eg[0].cyc == cyc) begin
        chk("gnt", gnt, eg[0].val);
        void'(eg.pop_front());
      end else begin
        chk("gnt_idle", gnt, 3'b000);
      end
      while (er.size() > 0 && er[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL rdata_stale: expected id %0h at cycle %0d never seen", er[0].id, er[0].cyc);
        void'(er.pop_front());
      end
      if (er.size() > 0 && er[0].cyc == cyc) begin
        chk("rdata_valid", rdata_valid, er[0].id);
        chk("read_data", read_data, er[0].data);
        void'(er.pop_front());
      end else begin
        chk("rdata_idle", rdata_valid, 3'b000);
      end
    end
  end

  // M1/UART continuous-write pattern, M1 first: 16 grants, one turn cycle, repeat.
  function automatic logic [2:0] t2_gnt(input int k);
    int p;
    if (k <= 0 || k >= 200) return 3'b000;
    p = (k - 1) % 34;
    if (p < 16) return 3'b010;
    if (p == 16 || p == 33) return 3'b000;
    return 3'b100;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, m1_wr, uart_wr;
    logic [2:0] prev;
    reset = 1'b1; req = '0; req_we_n = 3'b111; req_address = '0; req_write_data = '0;
    step(); step();
    @(negedge clock_50);
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rdata_valid", rdata_valid, 3'b000);
    chk("rst_we_n", SRAM_we_n, 1'b1);
    chk("rst_addr", SRAM_address, 18'h0);
    chk("rst_wdata", SRAM_write_data, 16'h0);
    chk("rst_read_data", read_data, 16'h0);
    step(); reset = 1'b0;
    step(); step();

    // M1 and UART writing continuously for 200 cycles
    c = cyc; m1_wr = 0; uart_wr = 0;
    for (int k = 0; k <= 200; k++) begin
      req = (k < 200) ? 3'b110 : 3'b000;
      req_we_n = 3'b001;
      req_write_data[1] = {4'h1, 12'(k)};
      req_write_data[2] = {4'h2, 12'(k)};
      req_address[1] = 18'h10000 + 18'(k);
      req_address[2] = 18'h20000 + 18'(k);
      if (t2_gnt(k) != 3'b000) push_g(c + k, t2_gnt(k));
      @(negedge clock_50);
      if (k >= 1) begin
        prev = t2_gnt(k - 1);
        chk("burst_we_n", SRAM_we_n, prev == 3'b000);
        if (prev != 3'b000)
          chk("burst_wdata", SRAM_write_data, {(prev == 3'b010) ? 4'h1 : 4'h2, 12'(k - 1)});
        if (!SRAM_we_n && SRAM_write_data[15:12] == 4'h1) m1_wr++;
        if (!SRAM_we_n && SRAM_write_data[15:12] == 4'h2) uart_wr++;
      end
      step();
    end
    chk("m1_write_count", m1_wr, 96);
    chk("uart_write_count", uart_wr, 92);
    step(); step();

    // UART burst preempted by VGA at burst count 5, then UART resumes
    c = cyc;
    for (int t = 1; t <= 6; t++) push_g(c + t, 3'b100);
    for (int t = 8; t <= 10; t++) begin
      push_g(c + t, 3'b001);
      push_r(c + t + 3, 3'b001, 18'h00100 + 18'(t - 8));
    end
    push_g(c + 13, 3'b100);
    push_g(c + 14, 3'b100);
    req_we_n = 3'b011;
    for (int t = 0; t < 18; t++) begin
      req = 3'b100;
      if (t >= 6 && t <= 10) req[0] = 1'b1;
      if (t >= 15) req = 3'b000;
      req_address[0] = 18'h00100 + 18'((t > 8) ? t - 8 : 0);
      step();
    end

    // M1 read in its last owned cycle before VGA takes over
    c = cyc;
    push_g(c + 1, 3'b010); push_g(c + 2, 3'b010); push_g(c + 4, 3'b001);
    push_r(c + 4, 3'b010, 18'h2A001);
    push_r(c + 5, 3'b010, 18'h2A002);
    push_r(c + 7, 3'b001, 18'h0ABCD);
    req_we_n = 3'b111;
    req_address[0] = 18'h0ABCD;
    for (int t = 0; t < 10; t++) begin
      req = {1'b0, 1'(t <= 2), 1'(t >= 2 && t <= 4)};
      req_address[1] = 18'h2A000 + 18'(t);
      step();
    end

    // Reset with two reads in flight
    c = cyc;
    push_g(c + 1, 3'b010); push_g(c + 2, 3'b010);
    req_address[1] = 18'h3ABCD;
    for (int t = 0; t < 11; t++) begin
      req = (t < 3) ? 3'b010 : 3'b000;
      if (t == 3) reset = 1'b1;
      if (t == 4) begin
        reset = 1'b0;
        @(negedge clock_50);
        chk("midrst_we_n", SRAM_we_n, 1'b1);
        chk("midrst_addr", SRAM_address, 18'h0);
      end
      step();
    end

    // All three requesters rise together, each takes one access
    c = cyc;
    push_g(c + 1, 3'b001); push_g(c + 4, 3'b010); push_g(c + 7, 3'b100);
    push_r(c + 4, 3'b001, 18'h01111);
    push_r(c + 7, 3'b010, 18'h12222);
    push_r(c + 10, 3'b100, 18'h23333);
    req_address[0] = 18'h01111; req_address[1] = 18'h12222; req_address[2] = 18'h23333;
    for (int t = 0; t < 13; t++) begin
      req = {1'(t < 8), 1'(t < 5), 1'(t < 2)};
      step();
    end

    // UART saturates its burst alone, then M1 arrives
    c = cyc;
    for (int t = 1; t <= 20; t++) push_g(c + t, 3'b100);
    push_g(c + 22, 3'b010);
    req_we_n = 3'b001;
    for (int t = 0; t < 26; t++) begin
      req = {1'(t <= 20), 1'(t >= 20 && t <= 22), 1'b0};
      step();
    end

    step(); step();
    chk("gnt_queue_drained", eg.size(), 0);
    chk("read_queue_drained", er.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
